instr_cache: RTL

- Direct-mapped, word-per-block instruction cache between the MIPS fetch stage and the backing instruction memory.
- It is the responder end of the fetch interface. It answers hits in the same cycle. On a miss it raises stall, runs a refill handshake to instruction memory, then delivers the word.
- Index is address bits [3:2] (4 blocks); tag is bits [31:4] (28 bits).
- Also keeps saturating hit/miss counters for bench observation.

---
 rtl/instr_cache.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between fetch and
// instruction memory: same-cycle hits, stalled refill on miss, saturating stats.
module instr_cache #(
  parameter int NUM_BLOCKS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             stall,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t                  state;
  logic [NUM_BLOCKS-1:0]   valid;
  logic [TAG_W-1:0]        tag_mem  [NUM_BLOCKS];
  logic [31:0]             data_mem [NUM_BLOCKS];
  logic [31:2]             miss_addr;
  logic [31:0]             fill_data;

  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        miss_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic                    unused_low_bits;

  assign unused_low_bits = ^cpu_addr[1:0];
  assign idx      = cpu_addr[IDX_W+1:2];
  assign req_tag  = cpu_addr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign hit      = (state == IDLE) && cpu_req && valid[idx] && (tag_mem[idx] == req_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      fill_data  <= '0;
      miss_addr  <= '0;
    end else begin
      // Flush clears first so a refill write on the same edge keeps its line valid.
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          if (hit) begin
            if (hit_count != '1)
              hit_count <= hit_count + 1'b1;
          end else if (cpu_req) begin
            miss_addr <= cpu_addr[31:2];
            if (miss_count != '1)
              miss_count <= miss_count + 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            valid[miss_idx]    <= 1'b1;
            tag_mem[miss_idx]  <= miss_addr[31:IDX_W+2];
            data_mem[miss_idx] <= mem_rdata;
            fill_data          <= mem_rdata;
            state              <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    stall     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[idx];
          end else if (cpu_req) begin
            stall = 1'b1;
          end
        end
        FETCH: stall = 1'b1;
        default: begin
          cpu_ready = 1'b1;
          cpu_rdata = fill_data;
        end
      endcase
    end
  end

  assign mem_req  = !reset && (state == FETCH);
  assign mem_addr = reset ? '0 : {miss_addr, 2'b00};

endmodule
